// File: rtl/pipe_pkg.sv
// Shared definitions for the execute-to-memory pipeline stage buffer.
// Widths of the optional performance counters (PIPE_STAGE_PERF_CNT_EN) live here too.
package pipe_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_REG_W  = 4;
    localparam int STALL_CNT_W    = 16;
    localparam int DROP_CNT_W     = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    // Packed payload: wre, wb_sel, mem_we, rs1, rs2, alu, srca, srcb, rd.
    function automatic int payload_w(input int data_w, input int reg_w);
        return 3 + 2 * reg_w + 4 * data_w;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload entry of the stage buffer: a register with load enable and synchronous reset.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb data_d = load ? d : data_q;

    // NOTE: reset is sampled on the clock edge only (synchronous) and wins over load.
    always_ff @(posedge clk) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Two-entry skid buffer between execute and memory stages with flush.
// Define PIPE_STAGE_PERF_CNT_EN to add the stall_cnt / drop_cnt performance counters.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int REG_W  = DEFAULT_REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wre,
    input  logic              in_wb_sel,
    input  logic              in_mem_we,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_srca,
    input  logic [DATA_W-1:0] in_srcb,
    input  logic [DATA_W-1:0] in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wre,
    output logic              out_wb_sel,
    output logic              out_mem_we,
    output logic [REG_W-1:0]  out_rs1,
    output logic [REG_W-1:0]  out_rs2,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_srca,
    output logic [DATA_W-1:0] out_srcb,
    output logic [DATA_W-1:0] out_rd
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [DROP_CNT_W-1:0]  drop_cnt
`endif
);

    localparam int PAY_W = payload_w(DATA_W, REG_W);

    occ_e             state_d;
    occ_e             state_q;
    logic             in_ready_d;
    logic             in_ready_q;
    logic             head_load;
    logic             skid_load;
    logic             head_from_skid;
    logic             push;
    logic             pop;
    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] head_d;
    logic [PAY_W-1:0] head_q;
    logic [PAY_W-1:0] skid_q;
    logic             head_wre;
    logic             head_mem_we;

    assign in_pay = {in_wre, in_wb_sel, in_mem_we, in_rs1, in_rs2,
                     in_alu, in_srca, in_srcb, in_rd};

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_load = 1'b1;
                    end else if (push) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (pop) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != FULL);
        head_d     = head_from_skid ? skid_q : in_pay;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_slot #(.W(PAY_W)) u_head (
        .clk   (clk),
        .reset (reset),
        .load  (head_load),
        .d     (head_d),
        .q     (head_q)
    );

    pipe_slot #(.W(PAY_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_pay),
        .q     (skid_q)
    );

    assign {head_wre, out_wb_sel, head_mem_we, out_rs1, out_rs2,
            out_alu, out_srca, out_srcb, out_rd} = head_q;

    // Write enables are gated into bubbles; data fields keep their last value.
    assign out_wre    = head_wre && out_valid;
    assign out_mem_we = head_mem_we && out_valid;

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [DROP_CNT_W-1:0]  drop_cnt_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        // A flush only counts as a drop when it discards a held entry.
        if (flush && (state_q != EMPTY) && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule
